// File: rtl/key_entry_pkg.sv
// key_entry_pkg: key indices, digit count and FSM state encoding for the key entry front end
package key_entry_pkg;
   localparam int NUM_KEYS   = 5;
   localparam int NUM_DIGITS = 8;
   localparam int KEY_INC    = 0;
   localparam int KEY_DEC    = 1;
   localparam int KEY_LEFT   = 2;
   localparam int KEY_RIGHT  = 3;
   localparam int KEY_EDIT   = 4;
   typedef enum logic {IDLE = 1'b0, EDIT = 1'b1} state_t;
endpackage

// File: rtl/key_entry_debounce.sv
// key_debounce: synchroniser, debounce counter, stable level and press pulse for one key
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic press_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          stable_q, prev_q, press_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_i};
         prev_q  <= stable_q;
         press_q <= stable_q & ~prev_q;
         // any agreeing cycle restarts the count, so short glitches never flip the level
         if (sync_q[1] == stable_q) cnt_q <= '0;
         else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_q <= sync_q[1];
            cnt_q    <= '0;
         end else cnt_q <= cnt_q + 1'b1;
      end
   end
   assign press_o = press_q;
endmodule

// File: rtl/key_entry.sv
// key_entry: debounced five-key editor for an 8-digit BCD number with commit strobe
module key_entry
   import key_entry_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 1_000_000,
   parameter logic [31:0] INIT_VALUE      = 32'h0000_0000
) (
   input  logic        clk100mhz,
   input  logic        clr,
   input  logic [4:0]  key_in,
   output logic [31:0] number,
   output logic [2:0]  cursor,
   output logic        edit_mode,
   output logic        load_pulse
);
   localparam logic [2:0] CURSOR_MSD = 3'(NUM_DIGITS - 1);
   logic [NUM_KEYS-1:0] press;
   logic [31:0]         number_q;
   logic [2:0]          cursor_q;
   logic                load_q;
   logic [3:0]          dig, dig_inc, dig_dec;
   state_t              state_q;
   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk_i  (clk100mhz),
         .rst_i  (clr),
         .key_i  (key_in[k]),
         .press_o(press[k])
      );
   end
   always_comb begin
      dig     = number_q[{cursor_q, 2'b00} +: 4];
      dig_inc = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      dig_dec = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
   end
   always_ff @(posedge clk100mhz) begin
      if (clr) begin
         state_q  <= IDLE;
         number_q <= INIT_VALUE;
         cursor_q <= CURSOR_MSD;
         load_q   <= 1'b0;
      end else begin
         load_q <= 1'b0;
         // edit/commit outranks everything; the remaining keys only act while editing
         if (press[KEY_EDIT]) begin
            cursor_q <= CURSOR_MSD;
            state_q  <= (state_q == IDLE) ? EDIT : IDLE;
            load_q   <= (state_q == EDIT);
         end else if (state_q == EDIT) begin
            if (press[KEY_INC]) number_q[{cursor_q, 2'b00} +: 4] <= dig_inc;
            else if (press[KEY_DEC]) number_q[{cursor_q, 2'b00} +: 4] <= dig_dec;
            else if (press[KEY_LEFT]) cursor_q <= cursor_q + 3'd1;
            else if (press[KEY_RIGHT]) cursor_q <= cursor_q - 3'd1;
         end
      end
   end
   assign number     = number_q;
   assign cursor     = cursor_q;
   assign edit_mode  = (state_q == EDIT);
   assign load_pulse = load_q;
endmodule
